// File: rtl/exu_pkg.sv
// exu_pkg: shared constants and types for the execute-unit issue controller.
// Channel map, default multi-cycle mask and GPR sizing.
package exu_pkg;

  localparam int EXU_CHN_NUM   = 4;
  localparam int CHN_ALU       = 0;
  localparam int CHN_BRANCH    = 1;
  localparam int CHN_LDST      = 2;
  localparam int CHN_MISC      = 3;
  localparam int EXU_GPR_NUM   = 32;
  localparam int EXU_GPR_IDX_W = 5;

  localparam logic [EXU_CHN_NUM-1:0] EXU_MC_MASK = 4'b0110;

  typedef enum logic {
    CHN_IDLE,
    CHN_BUSY
  } chn_st_e;

endpackage

// File: rtl/exu_scoreboard.sv
// exu_scoreboard: GPR pending-write bitmap with RAW/WAW lookup.
// A set and a clear of the same GPR in one cycle leaves it pending.
module exu_scoreboard #(
  parameter int GPR_NUM   = 32,
  parameter int GPR_IDX_W = 5,
  parameter int CHN_NUM   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         set_en,
  input  logic [GPR_IDX_W-1:0]         set_rd,
  input  logic [CHN_NUM-1:0]           clr_en,
  input  logic [CHN_NUM*GPR_IDX_W-1:0] clr_rd,
  input  logic                         rs1_en,
  input  logic                         rs2_en,
  input  logic                         rd_en,
  input  logic [GPR_IDX_W-1:0]         rs1,
  input  logic [GPR_IDX_W-1:0]         rs2,
  input  logic [GPR_IDX_W-1:0]         rd,
  output logic [GPR_NUM-1:0]           pend,
  output logic                         raw,
  output logic                         waw
);

  logic [GPR_NUM-1:0] set_vec;
  logic [GPR_NUM-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_rd != '0)
      set_vec[set_rd] = 1'b1;
    for (int i = 0; i < CHN_NUM; i++) begin
      if (clr_en[i] &&
          clr_rd[i*GPR_IDX_W +: GPR_IDX_W] != '0)
        clr_vec[clr_rd[i*GPR_IDX_W +: GPR_IDX_W]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend <= '0;
    else
      pend <= (pend & ~clr_vec) | set_vec;
  end

  // x0 is never written, so it can never hazard
  assign raw = (rs1_en && rs1 != '0 && pend[rs1])
            || (rs2_en && rs2 != '0 && pend[rs2]);
  assign waw = rd_en && rd != '0 && pend[rd];

endmodule

// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: issues decoded requests to generic handler channels,
// tracking multi-cycle channel occupancy and GPR write hazards.
module exu_issue_ctrl
  import exu_pkg::*;
#(
  parameter int                 CHN_NUM     = EXU_CHN_NUM,
  parameter logic [CHN_NUM-1:0] CHN_MC_MASK = EXU_MC_MASK,
  parameter int                 GPR_NUM     = EXU_GPR_NUM,
  parameter int                 GPR_IDX_W   = EXU_GPR_IDX_W,
  parameter int                 CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_vld,
  output logic                         req_rdy,
  input  logic [CHN_NUM-1:0]           req_chn,
  input  logic                         req_serial,
  input  logic                         req_rs1_en,
  input  logic                         req_rs2_en,
  input  logic                         req_rd_en,
  input  logic [GPR_IDX_W-1:0]         req_rs1,
  input  logic [GPR_IDX_W-1:0]         req_rs2,
  input  logic [GPR_IDX_W-1:0]         req_rd,
  input  logic                         flush,
  output logic [CHN_NUM-1:0]           iss_vld,
  input  logic [CHN_NUM-1:0]           iss_rdy,
  input  logic [CHN_NUM-1:0]           done,
  input  logic [CHN_NUM-1:0]           done_wb_en,
  input  logic [CHN_NUM*GPR_IDX_W-1:0] done_rd,
  output logic [CHN_NUM-1:0]           chn_busy,
  output logic [GPR_NUM-1:0]           sb_pend,
  output logic                         illegal,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic               chn_oh;
  logic               raw;
  logic               waw;
  logic               ser_blk;
  logic               can_iss;
  logic [CHN_NUM-1:0] done_act;
  logic [CHN_NUM-1:0] iss_mc;

  assign chn_oh = (req_chn != '0)
               && ((req_chn & (req_chn - CHN_NUM'(1))) == '0);

  assign ser_blk = req_serial && (|chn_busy);

  assign can_iss = req_vld && !flush && chn_oh
                && !raw && !waw && !ser_blk
                && !(|(req_chn & chn_busy))
                && (|(req_chn & iss_rdy));

  assign iss_vld = req_chn & {CHN_NUM{can_iss}};
  assign req_rdy = req_vld && (flush || can_iss);
  assign illegal = req_vld && !flush && !chn_oh;

  // done only counts on a multi-cycle channel that is actually busy
  assign done_act = done & CHN_MC_MASK & chn_busy;
  assign iss_mc   = iss_vld & CHN_MC_MASK;

  exu_scoreboard #(
    .GPR_NUM   (GPR_NUM),
    .GPR_IDX_W (GPR_IDX_W),
    .CHN_NUM   (CHN_NUM)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (|iss_mc && req_rd_en),
    .set_rd (req_rd),
    .clr_en (done_act & done_wb_en),
    .clr_rd (done_rd),
    .rs1_en (req_rs1_en),
    .rs2_en (req_rs2_en),
    .rd_en  (req_rd_en),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .rd     (req_rd),
    .pend   (sb_pend),
    .raw    (raw),
    .waw    (waw)
  );

  for (genvar i = 0; i < CHN_NUM; i++) begin : g_chn
    if (CHN_MC_MASK[i]) begin : g_mc
      chn_st_e st_q;
      chn_st_e st_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          st_q <= CHN_IDLE;
        else
          st_q <= st_d;
      end

      always_comb begin
        st_d = st_q;
        unique case (st_q)
          CHN_IDLE:
            if (iss_mc[i]) st_d = CHN_BUSY;
          CHN_BUSY:
            if (done_act[i] && !iss_mc[i]) st_d = CHN_IDLE;
        endcase
      end

      assign chn_busy[i] = (st_q == CHN_BUSY);
    end else begin : g_sc
      assign chn_busy[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (req_vld && !req_rdy && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
